seq_divider_restoring: RTL and testbench

- Multi-cycle unsigned integer divider built on repeated trial subtraction, one quotient bit per clock (restoring algorithm).
- It is the inverse-arithmetic partner of the team's adder/add-sub blocks: those compute A+B or A-B; this block recovers quotient and remainder.
- It sits beside the existing adders in the arithmetic library and is driven by a controller through a start/busy/done handshake.

---
 rtl/seq_divider_restoring_if.sv | 26 ++
 rtl/seq_divider_restoring.sv | 99 +++++++++
 tb/tb_seq_divider_restoring.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_restoring_if.sv
// Start/busy/done handshake bundle for the restoring divider.
// The controller holds start with stable operands; the divider takes them on the
// first rising edge it sees start while idle and answers with a one-cycle done.
interface seq_divider_restoring_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic [1:0]       dbg_state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, dbg_state
  );
endinterface

// File: rtl/seq_divider_restoring.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH iterations,
// with a divide-by-zero shortcut that reports quotient = all ones.
module seq_divider_restoring #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_p,
  seq_divider_restoring_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_r_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;

  // The partial remainder is WIDTH+1 bits wide only for the shifted trial value;
  // after each restore it is below the divisor, so its top bit is always zero.
  assign w_r_shift = {r_r, r_q[WIDTH-1]};
  assign w_trial   = w_r_shift - {1'b0, r_d};
  assign w_r_next  = w_trial[WIDTH] ? w_r_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_q_next  = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
              r_state     <= S_FIN;
            end else begin
              r_q     <= bus.dividend;
              r_d     <= bus.divisor;
              r_r     <= '0;
              r_cnt   <= '0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next;
            r_dbz       <= 1'b0;
            r_state     <= S_FIN;
          end
        end
        // done lags FIN by one edge so it lands in the first IDLE cycle
        S_FIN: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_seq_divider_restoring.sv
// Directed and swept checks of the restoring divider: latency, results,
// divide-by-zero, ignored restarts, async reset abort and back-to-back spacing.
module tb_seq_divider_restoring;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset_p = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  logic [WIDTH-1:0] last_q = '0;
  logic [WIDTH-1:0] last_r = '0;
  logic [2*WIDTH:0]   exp_q[$];
  logic [2*WIDTH-1:0] op_q[$];
  int                 gap_q[$];

  seq_divider_restoring_if #(.WIDTH(WIDTH)) bus();

  seq_divider_restoring #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one complete division with hand-computed expectations
  task automatic do_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                        input logic ez, input int elat);
    int lat;
    lat = 0;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
    chk({tag, "_busy_after_accept"}, bus.busy, 1);
    if (b != '0) begin
      chk({tag, "_hold_q"}, bus.quotient, last_q);
      chk({tag, "_hold_r"}, bus.remainder, last_r);
    end
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_quotient"}, bus.quotient, eq);
    chk({tag, "_remainder"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.div_by_zero, ez);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    tick();
    chk({tag, "_done_one_cycle"}, bus.done, 0);
    chk({tag, "_busy_after_done"}, bus.busy, 0);
    last_q = eq;
    last_r = er;
  endtask

  task automatic pick_pair(input int k, output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
    a = (k % 7 == 0) ? 8'd0 : (k % 7 == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    b = (k % 5 == 0) ? 8'd0 : (k % 5 == 2) ? 8'd255 : (k % 5 == 3) ? 8'd1
                     : 8'($urandom_range(0, 255));
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    op_q.push_back({a, b});
    if (b == '0) begin
      exp_q.push_back({1'b1, 8'd255, a});
      gap_q.push_back(2);
    end else begin
      exp_q.push_back({1'b0, 8'(a / b), 8'(a % b)});
      gap_q.push_back(WIDTH + 2);
    end
  endtask

  // back-to-back sweep: each new start is raised in the done cycle of the previous one
  task automatic sweep(input int n);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH:0]   e;
    logic [2*WIDTH-1:0] op;
    int gap;
    int egap;
    pick_pair(0, a, b);
    issue(a, b);
    for (int k = 0; k < n; k++) begin
      gap = 0;
      do begin
        tick();
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom_range(0, 255));
        bus.divisor  = 8'($urandom_range(0, 255));
        gap++;
      end while (!bus.done && gap < 20);
      chk("sweep_done", bus.done, 1);
      if (!bus.done) break;
      e    = exp_q.pop_front();
      op   = op_q.pop_front();
      egap = gap_q.pop_front();
      chk("sweep_gap", gap, egap);
      chk("sweep_dbz", bus.div_by_zero, e[2*WIDTH]);
      chk("sweep_quotient", bus.quotient, e[2*WIDTH-1:WIDTH]);
      chk("sweep_remainder", bus.remainder, e[WIDTH-1:0]);
      if (op[WIDTH-1:0] != '0) begin
        chk("sweep_invariant", int'(bus.quotient) * int'(op[WIDTH-1:0]) + int'(bus.remainder),
            int'(op[2*WIDTH-1:WIDTH]));
        chk("sweep_rem_lt_div", (bus.remainder < op[WIDTH-1:0]), 1);
      end
      if (k < n - 1) begin
        pick_pair(k + 1, a, b);
        issue(a, b);
      end
    end
    tick();
    last_q = bus.quotient;
    last_r = bus.remainder;
  endtask

  initial begin
    int lat;
    int extra;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #2 reset_p = 1'b1;
    repeat (3) tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_quotient", bus.quotient, 0);
    chk("reset_remainder", bus.remainder, 0);
    chk("reset_dbz", bus.div_by_zero, 0);
    chk("reset_state", bus.dbg_state, 0);
    @(negedge clk);
    reset_p = 1'b0;
    tick();

    do_div("d100_7",   8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9);
    do_div("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9);
    do_div("d5_9",     8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9);
    do_div("d255_255", 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9);
    do_div("d254_16",  8'd254, 8'd16,  8'd15,  8'd14,  1'b0, 9);
    do_div("d0_5",     8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9);
    do_div("d200_0",   8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 1);
    do_div("d9_3",     8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 9);

    // restart attempts during CALC and during FIN must be ignored
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
    tick();
    bus.dividend = 8'd1; bus.divisor = 8'd1;
    tick();
    bus.start = 1'b0;
    lat = 4;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
      if (lat == 8) begin
        chk("restart_in_fin_state", bus.dbg_state, 2);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("restart_done", bus.done, 1);
    chk("restart_latency", lat, 9);
    chk("restart_quotient", bus.quotient, 14);
    chk("restart_remainder", bus.remainder, 2);
    extra = 0;
    repeat (15) begin
      tick();
      if (bus.done) extra++;
    end
    chk("restart_no_second_done", extra, 0);
    last_q = 8'd14;
    last_r = 8'd2;

    // asynchronous reset in the middle of CALC
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    #2 reset_p = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_dbz", bus.div_by_zero, 0);
    chk("abort_state", bus.dbg_state, 0);
    @(negedge clk);
    reset_p = 1'b0;
    extra = 0;
    repeat (12) begin
      tick();
      if (bus.done || bus.busy) extra++;
    end
    chk("abort_stays_idle", extra, 0);
    last_q = '0;
    last_r = '0;
    do_div("d17_4", 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 9);

    sweep(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
